// File: rtl/atcaxi2tluh500_sync_multi.sv
// rtl/atcaxi2tluh500_sync_multi.sv - multi-channel level synchronizer with optional glitch filter and edge pulses
//
// Purpose : Brings WIDTH independent asynchronous level inputs into the clk domain
//           through SYNC_STAGE flops each. It optionally filters out levels that
//           are not stable for FILTER_CYCLES cycles, and flags q transitions with
//           one-cycle rise/fall pulses.
// Macro   : ATCAXI2TLUH500_SYNC_FILTER_EN - when defined, builds the per-channel
//           glitch filter. When undefined, q is s registered once and
//           FILTER_CYCLES is ignored.
// Ports   : clk    - destination clock, all state on posedge
//           resetn - synchronous active-low reset
//           d      - asynchronous level inputs, one per channel
//           q      - synchronized (and filtered) levels, registered
//           rise   - one-cycle pulse in the first cycle q[i] is 1 after 0
//           fall   - one-cycle pulse in the first cycle q[i] is 0 after 1

module atcaxi2tluh500_sync_multi #(
    parameter int               WIDTH         = 1,
    parameter int               SYNC_STAGE    = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE   = {WIDTH{1'b0}},
    parameter int               FILTER_CYCLES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    if (SYNC_STAGE < 2 || SYNC_STAGE > 4 || FILTER_CYCLES < 1 || FILTER_CYCLES > 255) begin : g_bad_param
        $error("atcaxi2tluh500_sync_multi: SYNC_STAGE or FILTER_CYCLES out of range");
    end

    logic [WIDTH-1:0] s;       // last synchronizer stage per channel
    logic [WIDTH-1:0] q_next;  // value q takes on the coming edge

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [SYNC_STAGE-1:0] sync_r;

        // Plain flop chain: no logic between stages, so metastability can settle.
        always_ff @(posedge clk) begin
            if (!resetn) begin
                sync_r <= {SYNC_STAGE{RESET_VALUE[i]}};
            end else begin
                sync_r <= {sync_r[SYNC_STAGE-2:0], d[i]};
            end
        end

        assign s[i] = sync_r[SYNC_STAGE-1];

`ifdef ATCAXI2TLUH500_SYNC_FILTER_EN
        localparam int             CW       = $clog2(FILTER_CYCLES + 1);
        localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_CYCLES - 1);

        logic [CW-1:0] cnt_r;
        logic [CW-1:0] cnt_next;
        logic          q_ch_next;

        // The counter only advances while s differs from q and stops at CNT_LAST,
        // where q is updated, so it saturates and never wraps. Any edge with s == q
        // (including a reversal mid-count) restarts the count from zero.
        always_comb begin
            q_ch_next = q[i];
            cnt_next  = cnt_r;
            if (s[i] == q[i]) begin
                cnt_next = '0;
            end else if (cnt_r == CNT_LAST) begin
                q_ch_next = s[i];
                cnt_next  = '0;
            end else begin
                cnt_next = cnt_r + CW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (!resetn) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_next;
            end
        end

        assign q_next[i] = q_ch_next;
`else
        assign q_next[i] = s[i];
`endif
    end

    // Edge pulses come from the q update itself, so they line up with the first
    // cycle of the new q level. Reset forces q without producing a pulse.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            q    <= RESET_VALUE;
            rise <= '0;
            fall <= '0;
        end else begin
            q    <= q_next;
            rise <= q_next & ~q;
            fall <= ~q_next & q;
        end
    end

endmodule

// File: doc/atcaxi2tluh500_sync_multi.md
ATCAXI2TLUH500_SYNC_MULTI -- requirements
Module: atcaxi2tluh500_sync_multi

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, number of independent single-bit level channels.
REQ-002 The block SHALL have parameter SYNC_STAGE, default 2, synchronizer flop depth per channel, legal range 2..4.
REQ-003 The block SHALL have parameter RESET_VALUE, default {WIDTH{1'b0}}, per-channel reset level of every synchronizer stage and of q.
REQ-004 The block SHALL have parameter FILTER_CYCLES, default 2, consecutive stable cycles required before q follows a new level, legal range 1..255.
REQ-005 The block SHALL have port resetn, input, 1, synchronous active-low reset sampled on posedge clk.
REQ-006 The block SHALL have port clk, input, 1, single destination clock; all state on posedge clk.
REQ-007 The block SHALL have port d, input, WIDTH, asynchronous level inputs, one per channel.
REQ-008 The block SHALL have port q, output, WIDTH, synchronized and filtered levels, registered.
REQ-009 The block SHALL have port rise, output, WIDTH, registered one-cycle pulse when q[i] goes 0->1.
REQ-010 The block SHALL have port fall, output, WIDTH, registered one-cycle pulse when q[i] goes 1->0.

Function
REQ-011 Each channel SHALL shift d[i] through SYNC_STAGE flops; s[i] = last stage; no logic between stages.
REQ-012 Channels SHALL be fully independent; no cross-channel coherence is provided.
REQ-013 Each channel SHALL hold a counter cnt[i] of width $clog2(FILTER_CYCLES+1), saturating, never wrapping.
REQ-014 On an edge where s[i]==q[i], cnt[i] SHALL clear to 0 and q[i] SHALL hold.
REQ-015 On an edge where s[i]!=q[i] and cnt[i]<FILTER_CYCLES-1, cnt[i] SHALL increment and q[i] SHALL hold.
REQ-016 On an edge where s[i]!=q[i] and cnt[i]==FILTER_CYCLES-1, q[i] SHALL take s[i] and cnt[i] SHALL clear.
REQ-017 A level change on d[i] stable from before edge N SHALL appear on q[i] after edge N+SYNC_STAGE+FILTER_CYCLES-1 (total latency SYNC_STAGE+FILTER_CYCLES edges).
REQ-018 s[i] pulses shorter than FILTER_CYCLES cycles SHALL NOT change q[i]; a reversal mid-count restarts counting from 0.
REQ-019 rise[i] SHALL be 1 in exactly the first cycle q[i] is 1 after being 0; fall[i] likewise for 1->0; both never high together.
REQ-020 rise/fall SHALL be derived from the registered q update, not from s, so pulses align with the q transition cycle.

Reset
REQ-021 While resetn==0 at posedge clk, all sync stages and q SHALL load RESET_VALUE, cnt SHALL load 0, rise and fall SHALL load 0.
REQ-022 Reset asserted mid-count SHALL discard the count; no rise/fall SHALL be generated by reset entry or exit.
REQ-023 After reset release, a d[i] level differing from RESET_VALUE[i] SHALL be treated as a normal level change per REQ-017.

Configuration
REQ-024 With macro ATCAXI2TLUH500_SYNC_FILTER_EN defined, the glitch filter of REQ-013..REQ-018 SHALL be built.
REQ-025 Without ATCAXI2TLUH500_SYNC_FILTER_EN, no counters SHALL exist, q SHALL equal s registered-through (q[i] <= s[i] each edge), latency SYNC_STAGE+1 edges, FILTER_CYCLES ignored; rise/fall SHALL still be generated.

Verification (WIDTH=4, SYNC_STAGE=2, FILTER_CYCLES=3, RESET_VALUE=4'h0, macro defined unless noted)
REQ-026 resetn=0 for 3 edges with d=4'hF -> q=4'h0, rise=fall=4'h0; release with d=4'hF held -> q=4'hF after 5th edge, rise=4'hF for exactly 1 cycle.
REQ-027 d[0] high for 2 cycles then low -> q[0] stays 0, rise[0] and fall[0] never assert.
REQ-028 d[1] high for 3 cycles then low -> q[1] high for exactly 3 cycles, one rise[1] pulse then one fall[1] pulse 3 cycles later.
REQ-029 d[2] high, resetn=0 for one edge when cnt[2]==2 -> q[2]=0, cnt[2]=0, no pulse; with d[2] still high q[2] rises 5 edges after release.
REQ-030 Macro undefined, d[3] high 1 cycle -> q[3] high 1 cycle after 3 edges, rise[3] then fall[3] on consecutive cycles.
REQ-031 SYNC_STAGE=3, d=4'hA stable -> q=4'hA after 6 edges, rise=4'hA one cycle, fall=4'h0 throughout.
